// File: rtl/level_ramp.sv
// Ramps the 7-bit mixer gain code one step per FRAMES_PER_STEP audio frames toward a
// clamped target (or MUTE_LEVEL while muted); frames come from a synchronised lrclk.
module level_ramp #(
  parameter int LEVEL_MAX       = 82,
  parameter int MUTE_LEVEL      = 0,
  parameter int RESET_LEVEL     = 0,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lrclk,
  input  logic       target_valid,
  input  logic [6:0] target,
  output logic       target_ready,
  input  logic       mute,
  output logic [6:0] level,
  output logic       busy,
  output logic       muted,
  output logic [1:0] dbg_state
);

  // Handshake: a target is taken on any clk edge where target_valid && target_ready;
  // target_ready is constantly 1, so the producer never stalls.

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);
  localparam logic [6:0] LMAX  = 7'(LEVEL_MAX);
  localparam logic [6:0] LMUTE = 7'(MUTE_LEVEL);
  localparam logic [6:0] LRST  = 7'(RESET_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t        r_state, w_next_state;
  logic          r_s1, r_s2, r_s3;
  logic [6:0]    r_level, r_target, w_next_level;
  logic [CW-1:0] r_cnt, w_next_cnt;
  logic          r_muted;
  logic          w_tick;
  logic [6:0]    w_goal_raw, w_goal, w_target_c;

  assign w_tick     = r_s2 & ~r_s3;
  assign w_target_c = (target > LMAX) ? LMAX : target;
  assign w_goal_raw = mute ? LMUTE : r_target;
  // Clamping the goal keeps saturation safe even if MUTE_LEVEL exceeds LEVEL_MAX.
  assign w_goal     = (w_goal_raw > LMAX) ? LMAX : w_goal_raw;

  always_comb begin
    w_next_state = r_state;
    w_next_level = r_level;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        if (w_goal > r_level)      w_next_state = S_UP;
        else if (w_goal < r_level) w_next_state = S_DOWN;
      end
      S_UP, S_DOWN: begin
        // A step on this tick follows the current state, even if the goal just moved.
        if (w_tick && (r_level != w_goal)) begin
          if (r_cnt == CNT_LAST) begin
            w_next_cnt = '0;
            if (r_state == S_UP && r_level < LMAX)         w_next_level = r_level + 7'd1;
            else if (r_state == S_DOWN && r_level > 7'd0)  w_next_level = r_level - 7'd1;
          end else begin
            w_next_cnt = r_cnt + CW'(1);
          end
        end
        if (r_level == w_goal)     w_next_state = S_IDLE;
        else if (w_goal > r_level) w_next_state = S_UP;
        else                       w_next_state = S_DOWN;
        if (w_next_state != r_state) w_next_cnt = '0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_state  <= S_IDLE;
      r_level  <= LRST;
      r_target <= LRST;
      r_cnt    <= '0;
      r_muted  <= 1'b0;
    end else begin
      r_s1    <= lrclk;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_state <= w_next_state;
      r_level <= w_next_level;
      r_cnt   <= w_next_cnt;
      r_muted <= mute && (r_level == LMUTE);
      if (target_valid && target_ready) r_target <= w_target_c;
    end
  end

  assign target_ready = 1'b1;
  assign level        = r_level;
  assign busy         = (r_state != S_IDLE);
  assign muted        = r_muted;
  assign dbg_state    = r_state;

endmodule
